// File: rtl/loader_pkg.sv
// Shared state types and width constants for the UART boot loader.
// Build option: LOADER_CHECKSUM_EN adds the trailing checksum state.
package loader_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;
endpackage

// File: rtl/uart_rx.sv
// 8N1 deserialiser with a 2-flop input synchroniser and centre-of-bit sampling.
// Emits a one-cycle byte_valid on a good stop bit, or a one-cycle frame_err on a bad one.
module uart_rx import loader_pkg::*; #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rx,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_byte_valid,
  output logic              o_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // r_sync[1] is the synchronised line, r_sync[2] its previous value for edge detection
  logic [2:0]        r_sync;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_bit;
  logic [BYTE_W-1:0] r_shift;
  rx_state_e         r_state;
  logic              w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync       <= '1;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_state      <= R_IDLE;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      r_sync       <= {r_sync[1:0], i_rx};
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      case (r_state)
        R_IDLE: if (!r_sync[1] && r_sync[2]) begin
          r_state <= R_START;
          r_cnt   <= HALF;
        end
        R_START: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else if (w_rx) r_state <= R_IDLE;
          else begin
            r_state <= R_DATA;
            r_cnt   <= FULL;
            r_bit   <= '0;
          end
        R_DATA: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_shift <= {w_rx, r_shift[BYTE_W-1:1]};
            r_cnt   <= FULL;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= R_STOP;
          end
        R_STOP: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_state <= R_IDLE;
            if (w_rx) begin
              o_byte       <= r_shift;
              o_byte_valid <= 1'b1;
            end else begin
              o_frame_err  <= 1'b1;
            end
          end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_loader.sv
// UART boot loader: length-prefixed little-endian word stream written out as addr/data strobes.
// Build option: LOADER_CHECKSUM_EN requires a trailing sum-of-words before completion.
//   state  | meaning
//   S_LEN  | assembling the 4-byte word count
//   S_DATA | assembling data words, one strobe per word
//   S_CSUM | assembling the checksum word (LOADER_CHECKSUM_EN only)
//   S_DONE | load complete, absorbing
//   S_ERR  | load aborted, absorbing
module uart_loader import loader_pkg::*; #(
  parameter int          CLK_FREQ  = 100_000_000,
  parameter int          BAUD      = 115_200,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [WORD_W-1:0] uart_data,
  output logic [WORD_W-1:0] uart_addr,
  output logic              uart_we,
  output logic              uart_done,
  output logic              err
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [WORD_W-1:0] MAX_N = WORD_W'(MAX_WORDS);

  logic [BYTE_W-1:0]        w_byte;
  logic                     w_byte_valid;
  logic                     w_frame_err;
  logic [WORD_W-1:0]        w_word;
  logic                     w_active;
  state_e                   r_state;
  logic [1:0]               r_byte_cnt;
  logic [WORD_W-1:0]        r_word_cnt;
  logic [WORD_W-1:0]        r_len;
  logic [WORD_W-BYTE_W-1:0] r_shift;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]        r_sum;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  // The incoming byte completes the word as its most significant byte
  assign w_word   = {w_byte, r_shift};
  assign w_active = (r_state != S_DONE) && (r_state != S_ERR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_LEN;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_len      <= '0;
      r_shift    <= '0;
      uart_data  <= '0;
      uart_addr  <= BASE_ADDR;
      uart_we    <= 1'b0;
      uart_done  <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      uart_we <= 1'b0;
      if (w_active && w_frame_err) begin
        r_state <= S_ERR;
        err     <= 1'b1;
      end else if (w_active && w_byte_valid) begin
        r_shift    <= w_word[WORD_W-1:BYTE_W];
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          case (r_state)
            S_LEN: if (w_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state   <= S_CSUM;
`else
              r_state   <= S_DONE;
              uart_done <= 1'b1;
`endif
            end else if (w_word > MAX_N) begin
              r_state <= S_ERR;
              err     <= 1'b1;
            end else begin
              r_state    <= S_DATA;
              r_len      <= w_word;
              r_word_cnt <= '0;
              r_byte_cnt <= '0;
            end
            S_DATA: begin
              uart_data  <= w_word;
              uart_addr  <= BASE_ADDR + {r_word_cnt[WORD_W-3:0], 2'b00};
              uart_we    <= 1'b1;
              r_word_cnt <= r_word_cnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
              r_sum      <= r_sum + w_word;
              if (r_word_cnt == r_len - 32'd1) r_state <= S_CSUM;
`else
              if (r_word_cnt == r_len - 32'd1) begin
                r_state   <= S_DONE;
                uart_done <= 1'b1;
              end
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: if (w_word == r_sum) begin
              r_state   <= S_DONE;
              uart_done <= 1'b1;
            end else begin
              r_state <= S_ERR;
              err     <= 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end
endmodule
